// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the sequential ALU.
//   alu_op_t    - ALUctl opcode encodings
//   alu_flags_t - registered flag bundle {carryout, overflow, negative, zero}
//   alu_state_t - control FSM states
package alu_seq_pkg;

  localparam int OP_WIDTH = 4;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_MUL = 4'b0011,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_SRA = 4'b1010,
    OP_NOR = 4'b1100
  } alu_op_t;

  typedef struct packed {
    logic carryout;
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  // Flags describing ALUOut = 0, the reset value of the result register.
  localparam alu_flags_t FLAGS_RST = '{carryout: 1'b0, overflow: 1'b0,
                                       negative: 1'b0, zero: 1'b1};

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the register-read stage
// (master) and the sequential ALU (slave).
//   start, ALUctl, A, B                          - request, master -> slave
//   ready, done, ALUOut, carryout, zero,
//   overflow, negative                           - status/result, slave -> master
interface alu_seq_if #(parameter int WIDTH = 64);
  import alu_seq_pkg::*;

  logic                start;
  logic [OP_WIDTH-1:0] ALUctl;
  logic [WIDTH-1:0]    A;
  logic [WIDTH-1:0]    B;
  logic                ready;
  logic                done;
  logic [WIDTH-1:0]    ALUOut;
  logic                carryout;
  logic                zero;
  logic                overflow;
  logic                negative;

  modport master (
    output start, ALUctl, A, B,
    input  ready, done, ALUOut, carryout, zero, overflow, negative
  );

  modport slave (
    input  start, ALUctl, A, B,
    output ready, done, ALUOut, carryout, zero, overflow, negative
  );

endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one partial product per cycle.
//   clk, reset - clock, synchronous active-high reset
//   go         - load operands and start (only issued while idle)
//   a, b       - unsigned operands, sampled when go=1
//   busy       - an operation is in flight
//   fin        - last step happens on this cycle's edge
//   prod       - full 2*WIDTH product, valid while fin=1
module alu_seq_mul #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               fin,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (go) begin
      cnt_d    = CW'(WIDTH);
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign fin  = (cnt_q == CW'(1));
  // Exposes the post-step accumulator so the caller can register the final
  // product on the same edge as the last step, saving a cycle of latency.
  assign prod = acc_d;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Single-cycle ops register their result on the
// accepting edge; MUL runs WIDTH cycles in alu_seq_mul. Result and flags are
// held until the next done pulse.
//   clk, reset - clock, synchronous active-high reset
//   bus        - alu_seq_if slave: start/ALUctl/A/B in,
//                ready/done/ALUOut/flags out
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready=1; a start is accepted; non-MUL ops complete here
// ST_MUL  | ready=0; multiplier stepping, result loads on its last step
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_state_t         state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  alu_flags_t         flags_q, flags_d;
  logic               done_q, done_d;
  logic               ready;

  logic               mul_go, mul_busy, mul_fin;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v;
  logic [WIDTH:0]     add_w, sub_w;
  logic [SHW-1:0]     shamt;

  assign shamt = bus.B[SHW-1:0];
  assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
  // A + ~B + 1: the carry out is the "no borrow" indication.
  assign sub_w = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.ALUctl)
      OP_AND: sc_res = bus.A & bus.B;
      OP_OR:  sc_res = bus.A | bus.B;
      OP_NOR: sc_res = ~(bus.A | bus.B);
      OP_ADD: begin
        sc_res = add_w[MSB:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (bus.A[MSB] == bus.B[MSB]) && (add_w[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        sc_res = sub_w[MSB:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = (bus.A[MSB] != bus.B[MSB]) && (sub_w[MSB] != bus.A[MSB]);
      end
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLL: sc_res = bus.A << shamt;
      OP_SRL: sc_res = bus.A >> shamt;
      OP_SRA: sc_res = $unsigned($signed(bus.A) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // mul_busy is redundant with ST_MUL; gating on it keeps a stray go from
  // ever reloading an in-flight multiply.
  assign ready = (state_q == ST_IDLE) && !mul_busy;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    mul_go  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready && bus.start) begin
          if (bus.ALUctl == OP_MUL) begin
            mul_go  = 1'b1;
            state_d = ST_MUL;
          end else begin
            res_d            = sc_res;
            flags_d.carryout = sc_c;
            flags_d.overflow = sc_v;
            flags_d.negative = sc_res[MSB];
            flags_d.zero     = (sc_res == '0);
            done_d           = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_fin) begin
          res_d            = mul_prod[MSB:0];
          flags_d.carryout = 1'b0;
          flags_d.overflow = |mul_prod[2*WIDTH-1:WIDTH];
          flags_d.negative = mul_prod[MSB];
          flags_d.zero     = (mul_prod[MSB:0] == '0);
          done_d           = 1'b1;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      flags_q <= FLAGS_RST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .go    (mul_go),
    .a     (bus.A),
    .b     (bus.B),
    .busy  (mul_busy),
    .fin   (mul_fin),
    .prod  (mul_prod)
  );

  assign bus.ready    = ready;
  assign bus.done     = done_q;
  assign bus.ALUOut   = res_q;
  assign bus.carryout = flags_q.carryout;
  assign bus.overflow = flags_q.overflow;
  assign bus.negative = flags_q.negative;
  assign bus.zero     = flags_q.zero;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at WIDTH=8 (vector table,
// hand sequences, randomized ops against an arithmetic reference model) and
// WIDTH=64 (multiply latency and results).
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(64)) if64 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
  alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       c, v, n, z;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       c, v, n, z;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t ref8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, sh, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sh = ub % 8;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      4'b0000: r = ua & ub;
      4'b0001: r = ua | ub;
      4'b1100: r = ~(ua | ub);
      4'b0010: begin
        r   = ua + ub;
        e.c = (r > 255);
        e.v = (sa + sb > 127) || (sa + sb < -128);
      end
      4'b0110: begin
        r   = ua - ub;
        e.c = (ua >= ub);
        e.v = (sa - sb > 127) || (sa - sb < -128);
      end
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b1000: r = ua << sh;
      4'b1001: r = ua >> sh;
      4'b1010: r = sa >>> sh;
      4'b0011: begin
        r   = ua * ub;
        e.v = (r > 255);
      end
      default: r = 0;
    endcase
    e.out = r[7:0];
    e.n   = e.out[7];
    e.z   = (e.out == 8'h00);
    return e;
  endfunction

  task automatic chk_rst8(input string tag);
    chk({tag, ".ready"},    64'(if8.ready),    64'd1);
    chk({tag, ".done"},     64'(if8.done),     64'd0);
    chk({tag, ".ALUOut"},   64'(if8.ALUOut),   64'd0);
    chk({tag, ".carryout"}, 64'(if8.carryout), 64'd0);
    chk({tag, ".overflow"}, 64'(if8.overflow), 64'd0);
    chk({tag, ".negative"}, 64'(if8.negative), 64'd0);
    chk({tag, ".zero"},     64'(if8.zero),     64'd1);
  endtask

  task automatic chk_out8(input string tag, input exp_t e);
    chk({tag, ".ALUOut"},   64'(if8.ALUOut),   64'(e.out));
    chk({tag, ".carryout"}, 64'(if8.carryout), 64'(e.c));
    chk({tag, ".overflow"}, 64'(if8.overflow), 64'(e.v));
    chk({tag, ".negative"}, 64'(if8.negative), 64'(e.n));
    chk({tag, ".zero"},     64'(if8.zero),     64'(e.z));
  endtask

  // One op on the 8-bit DUT from idle; checks latency and results.
  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   lat;
    int   want;
    e = ref8(op, a, b);
    @(negedge clk);
    if8.start = 1'b1; if8.ALUctl = op; if8.A = a; if8.B = b;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 1;
    while (if8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    want = (op == 4'b0011) ? 9 : 1;
    chk($sformatf("rnd op=%b latency", op), 64'(lat), 64'(want));
    chk_out8($sformatf("rnd op=%b a=%h b=%h", op, a, b), e);
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] want_out,
                       input logic want_v, input logic want_n, input logic want_z);
    int lat;
    @(negedge clk);
    if64.start = 1'b1; if64.ALUctl = 4'b0011; if64.A = a; if64.B = b;
    @(negedge clk);
    if64.start = 1'b0;
    lat = 1;
    while (if64.done !== 1'b1 && lat < 100) begin
      chk("mul64.ready_low", 64'(if64.ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    chk("mul64.latency",  64'(lat),           64'd65);
    chk("mul64.ready",    64'(if64.ready),    64'd1);
    chk("mul64.ALUOut",   if64.ALUOut,        want_out);
    chk("mul64.carryout", 64'(if64.carryout), 64'd0);
    chk("mul64.overflow", 64'(if64.overflow), 64'(want_v));
    chk("mul64.negative", 64'(if64.negative), 64'(want_n));
    chk("mul64.zero",     64'(if64.zero),     64'(want_z));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    logic [3:0] legal[11];
    exp_t e;
    int cnt;

    tbl[0]  = '{4'b0010, 8'hA3, 8'hF5, 8'h98, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4'b0110, 8'hA3, 8'hF5, 8'hAE, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4'b0110, 8'h5C, 8'h5C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{4'b1010, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'b0111, 8'hA3, 8'hF5, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0111, 8'hF5, 8'hA3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0001, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'b1100, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'b1000, 8'h81, 8'hF1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b1001, 8'h81, 8'h0A, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'b1111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};

    legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
              4'b1000, 4'b1001, 4'b1010, 4'b0011, 4'b1111};

    reset = 1'b1;
    if8.start = 1'b0;  if8.ALUctl = '0;  if8.A = '0;  if8.B = '0;
    if64.start = 1'b0; if64.ALUctl = '0; if64.A = '0; if64.B = '0;
    repeat (2) @(negedge clk);
    chk_rst8("reset");
    chk("reset64.zero",  64'(if64.zero),  64'd1);
    chk("reset64.ready", 64'(if64.ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_rst8("post_reset");

    // MUL A3*F5 with an ignored start while busy.
    if8.start = 1'b1; if8.ALUctl = 4'b0011; if8.A = 8'hA3; if8.B = 8'hF5;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("mul.busy_c%0d.ready", k), 64'(if8.ready), 64'd0);
      chk($sformatf("mul.busy_c%0d.done", k),  64'(if8.done),  64'd0);
      if (k == 3) begin
        if8.start = 1'b1; if8.ALUctl = 4'b0010; if8.A = 8'h01; if8.B = 8'h01;
      end else begin
        if8.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("mul.done",  64'(if8.done),  64'd1);
    chk("mul.ready", 64'(if8.ready), 64'd1);
    e = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    chk_out8("mul", e);
    @(negedge clk);
    chk("mul.done_pulse", 64'(if8.done),   64'd0);
    chk("mul.held",       64'(if8.ALUOut), 64'hFF);

    // Reset during cycle N+4 of a MUL aborts it.
    if8.start = 1'b1; if8.ALUctl = 4'b0011; if8.A = 8'hA3; if8.B = 8'hF5;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_rst8("abort");
    reset = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done === 1'b1) cnt++;
    end
    chk("abort.no_done", 64'(cnt), 64'd0);

    // Vector table issued back to back, one op per clock.
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("tbl%0d.done", i-1),  64'(if8.done),  64'd1);
        chk($sformatf("tbl%0d.ready", i-1), 64'(if8.ready), 64'd1);
        e = '{tbl[i-1].out, tbl[i-1].c, tbl[i-1].v, tbl[i-1].n, tbl[i-1].z};
        chk_out8($sformatf("tbl%0d", i-1), e);
      end
      if (i < 14) begin
        if8.start = 1'b1; if8.ALUctl = tbl[i].op; if8.A = tbl[i].a; if8.B = tbl[i].b;
      end else begin
        if8.start = 1'b0;
      end
    end

    // Reset together with start: request dropped.
    @(negedge clk);
    reset = 1'b1;
    if8.start = 1'b1; if8.ALUctl = 4'b0010; if8.A = 8'h7F; if8.B = 8'h01;
    @(negedge clk);
    reset = 1'b0;
    if8.start = 1'b0;
    chk_rst8("rst_start");
    @(negedge clk);
    chk_rst8("rst_start2");

    for (int i = 0; i < 150; i++) begin
      run8(legal[$urandom_range(0, 10)], 8'($urandom), 8'($urandom));
    end

    run64(64'd3, 64'd5, 64'd15, 1'b0, 1'b0, 1'b0);
    run64(64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, 1'b0, 1'b1);
    run64(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
